// File: rtl/srff_cmd_debounce.sv
// Command front end for an asynchronously reset SR flip-flop: synchronises and
// debounces raw set/clear lines and issues mutually exclusive one-cycle s/r pulses.

module srff_cmd_debounce_chan #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = $clog2(DB_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic rise_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sy1_q;
    logic             sy2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sy1_q    <= 1'b0;
            sy2_q    <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sy1_q    <= raw_i;
            sy2_q    <= sy1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Any sample that agrees with the accepted level restarts the count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        accept   = 1'b0;
        if (sy2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                accept   = 1'b1;
                stable_d = sy2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Only 0->1 acceptances are requests; falling acceptances just track the level.
    assign rise_o = accept & sy2_q;

endmodule

module srff_cmd_debounce #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = $clog2(DB_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic set_in,
    input  logic clr_in,
    output logic s,
    output logic r,
    output logic conflict
);

    localparam int N_CH = 2;

    logic [N_CH-1:0] raw_vec;
    logic [N_CH-1:0] rise_vec;
    logic            s_q;
    logic            s_d;
    logic            r_q;
    logic            r_d;
    logic            conflict_q;
    logic            conflict_d;

    assign raw_vec = {clr_in, set_in};

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            srff_cmd_debounce_chan #(
                .DB_CYCLES (DB_CYCLES),
                .CNT_W     (CNT_W)
            ) u_chan (
                .clk    (clk),
                .rst_n  (rst),
                .raw_i  (raw_vec[gi]),
                .rise_o (rise_vec[gi])
            );
        end
    endgenerate

    // Simultaneous acceptance drops both requests so 11 can never reach the flop.
    always_comb begin
        s_d        = rise_vec[0] & ~rise_vec[1];
        r_d        = rise_vec[1] & ~rise_vec[0];
        conflict_d = rise_vec[0] &  rise_vec[1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            s_q        <= s_d;
            r_q        <= r_d;
            conflict_q <= conflict_d;
        end
    end

    assign s        = s_q;
    assign r        = r_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_srff_cmd_debounce.sv
// Scoreboard bench for srff_cmd_debounce: stimulus pushes expected pulses, a
// monitor pops and compares every pulse the DUT presents.

module tb_srff_cmd_debounce;

    typedef struct {
        int cyc;
        bit s;
        bit r;
        bit c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic set_in = 1'b1;
    logic clr_in = 1'b0;
    logic s;
    logic r;
    logic conflict;
    logic q_ff;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    exp_t e_mon;

    srff_cmd_debounce #(.DB_CYCLES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .set_in   (set_in),
        .clr_in   (clr_in),
        .s        (s),
        .r        (r),
        .conflict (conflict)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream SR flip-flop the pulses drive.
    always @(posedge clk or negedge rst) begin
        if (!rst)   q_ff <= 1'b0;
        else if (s) q_ff <= 1'b1;
        else if (r) q_ff <= 1'b0;
    end

    always @(negedge clk) begin
        n_tests++;
        if (s && r) begin
            n_fail++;
            $display("FAIL s_r_exclusive cyc=%0d: got s=%b r=%b, required not both 1", cyc, s, r);
        end
        if (s || r || conflict) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse cyc=%0d: got s=%b r=%b conflict=%b, required none", cyc, s, r, conflict);
            end else begin
                e_mon = exp_q.pop_front();
                if (e_mon.cyc != cyc || e_mon.s != s || e_mon.r != r || e_mon.c != conflict) begin
                    n_fail++;
                    $display("FAIL pulse cyc=%0d: got s=%b r=%b conflict=%b, required cyc=%0d s=%b r=%b conflict=%b",
                             cyc, s, r, conflict, e_mon.cyc, e_mon.s, e_mon.r, e_mon.c);
                end else begin
                    $display("[TB] pulse cyc=%0d s=%b r=%b conflict=%b ok", cyc, s, r, conflict);
                end
            end
        end
    end

    task automatic goto(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic expect_pulse(input int c, input bit es, input bit er, input bit ec);
        exp_t e;
        e.cyc = c;
        e.s   = es;
        e.r   = er;
        e.c   = ec;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic act, input logic req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %b, required %b", name, cyc, act, req);
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int b;
        // Reset held with set_in high; release so first post-release edge is 4.
        for (int i = 1; i <= 3; i++) begin
            goto(i);
            check("reset_s", s, 1'b0);
            check("reset_r", r, 1'b0);
            check("reset_conflict", conflict, 1'b0);
        end
        expect_pulse(9, 1, 0, 0);
        rst = 1'b1;
        goto(12); set_in = 1'b0;

        // Clean set then clean clear.
        b = 30;
        goto(b + 9);  set_in = 1'b1; expect_pulse(b + 15, 1, 0, 0);
        goto(b + 29); set_in = 1'b0;
        goto(b + 39); clr_in = 1'b1; expect_pulse(b + 45, 0, 1, 0);
        goto(b + 55); clr_in = 1'b0;

        // Three-sample burst rejected, then steady high from edge 20.
        b = 100;
        goto(b + 15); set_in = 1'b1;
        goto(b + 18); set_in = 1'b0;
        goto(b + 19); set_in = 1'b1; expect_pulse(b + 25, 1, 0, 0);
        goto(b + 35); set_in = 1'b0;

        // Simultaneous acceptance: conflict only, no later pulses while held.
        b = 150;
        goto(b + 29); set_in = 1'b1; clr_in = 1'b1; expect_pulse(b + 35, 0, 0, 1);
        goto(b + 60); set_in = 1'b0; clr_in = 1'b0;

        // Reset mid-debounce restarts the whole latency.
        b = 230;
        goto(b + 9);  set_in = 1'b1;
        goto(b + 12); rst = 1'b0;
        goto(b + 13);
        check("midreset_s", s, 1'b0);
        goto(b + 14); rst = 1'b1; expect_pulse(b + 20, 1, 0, 0);
        goto(b + 15);
        check("midreset_no_pulse", s, 1'b0);
        goto(b + 30); set_in = 1'b0;

        // Chain into the flip-flop: clear, set, clear, set.
        b = 280;
        goto(b + 9);  clr_in = 1'b1; expect_pulse(b + 15, 0, 1, 0);
        goto(b + 16); check("chain_q0", q_ff, 1'b0);
        goto(b + 20); clr_in = 1'b0;
        goto(b + 29); set_in = 1'b1; expect_pulse(b + 35, 1, 0, 0);
        goto(b + 34); check("chain_q_hold0", q_ff, 1'b0);
        goto(b + 36); check("chain_q1", q_ff, 1'b1);
        goto(b + 40); set_in = 1'b0;
        goto(b + 49); clr_in = 1'b1; expect_pulse(b + 55, 0, 1, 0);
        goto(b + 56); check("chain_q2", q_ff, 1'b0);
        goto(b + 60); clr_in = 1'b0;
        goto(b + 69); set_in = 1'b1; expect_pulse(b + 75, 1, 0, 0);
        goto(b + 76); check("chain_q3", q_ff, 1'b1);
        goto(b + 80); set_in = 1'b0;

        goto(b + 100);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_pulses: got %0d outstanding, required 0 (next cyc=%0d)",
                     exp_q.size(), exp_q[0].cyc);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
